// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM receive demultiplexer.
package tdm_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-NCH slot counter: synchronous clear, load-to-1 and increment-on-enable.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_slot,
  output logic             o_is_last_c
);

  logic [SEL_W-1:0] r_slot;

  // Clear beats load, load beats increment; the counter wraps naturally at NCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SEL_W'(1);
    end else if (i_inc) begin
      r_slot <= r_slot + SEL_W'(1);
    end
  end

  assign o_slot      = r_slot;
  assign o_is_last_c = (r_slot == SEL_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux_18.sv
// 1-bit 8-slot TDM receiver: steers slot bits into a shadow word and publishes once per frame.
// Optional saturating sync-error counter enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_demux_18
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [NCH-1:0]   y,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
`ifdef TDM_DEMUX_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             locked,
  output logic             sync_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NCH-1:0]   r_shadow;
  logic [NCH-1:0]   w_shadow_nxt;
  logic [NCH-1:0]   r_y;
  logic [NCH-1:0]   w_y_nxt;
  logic             r_frame_valid;
  logic             w_fv_nxt;
  logic             r_sync_err;
  logic             w_se_nxt;
  logic             r_locked;
  logic             w_clr;
  logic             w_load1;
  logic             w_inc;
  logic [SEL_W-1:0] w_slot;
  logic             w_is_last;

  tdm_slot_ctr u_slot_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_load1     (w_load1),
    .i_inc       (w_inc),
    .o_slot      (w_slot),
    .o_is_last_c (w_is_last)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUNT;
      r_shadow      <= '0;
      r_y           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shadow      <= w_shadow_nxt;
      r_y           <= w_y_nxt;
      r_frame_valid <= w_fv_nxt;
      r_sync_err    <= w_se_nxt;
      r_locked      <= (w_state_nxt == RUN);
    end
  end

  // Next-state and datapath decode; every frame start restarts the shadow from slot 0.
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_y_nxt      = r_y;
    w_fv_nxt     = 1'b0;
    w_se_nxt     = 1'b0;
    w_clr        = 1'b0;
    w_load1      = 1'b0;
    w_inc        = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_shadow_nxt = {{(NCH-1){1'b0}}, din};
            w_load1      = 1'b1;
            w_state_nxt  = RUN;
          end
        end
        RUN: begin
          if (frame_sync) begin
            // Early sync discards the partial frame and realigns on this bit.
            w_se_nxt     = (w_slot != '0);
            w_shadow_nxt = {{(NCH-1){1'b0}}, din};
            w_load1      = 1'b1;
          end else if (w_slot == '0) begin
            w_se_nxt    = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_shadow_nxt[w_slot] = din;
            w_inc                = 1'b1;
            if (w_is_last) begin
              w_y_nxt  = {din, r_shadow[NCH-2:0]};
              w_fv_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of framing violations, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_se_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign y           = r_y;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux_18.sv
// Self-checking bench for tdm_demux_18 with a frame-level reference model.
module tb_tdm_demux_18;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a run of 8 valid bits opened by frame_sync.
  bit       m_hunting;
  bit [7:0] m_buf;
  int       m_cnt;
  bit [7:0] m_y;
  bit       m_fv;
  bit       m_se;
  int       m_errs;
  int       last_fv_cycle;
  int       cycle;

  always #5 clk = ~clk;

  tdm_demux_18 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .y           (y),
    .frame_valid (frame_valid),
    .slot        (slot),
`ifdef TDM_DEMUX_ERRCNT_EN
    .err_cnt     (err_cnt),
`endif
    .locked      (locked),
    .sync_err    (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_se));
    chk({tag, ".slot"}, 32'(slot), 32'(m_cnt));
    chk({tag, ".locked"}, 32'(locked), 32'(!m_hunting));
`ifdef TDM_DEMUX_ERRCNT_EN
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'((m_errs > 255) ? 255 : m_errs));
`endif
  endtask

  task automatic model_bit(input bit v, input bit fs, input bit d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (!v) return;
    if (m_hunting) begin
      if (fs) begin
        m_hunting = 1'b0;
        m_buf     = 8'h00;
        m_buf[0]  = d;
        m_cnt     = 1;
      end
    end else if (fs) begin
      if (m_cnt != 0) begin
        m_se = 1'b1;
        m_errs++;
      end
      m_buf    = 8'h00;
      m_buf[0] = d;
      m_cnt    = 1;
    end else if (m_cnt == 0) begin
      m_se = 1'b1;
      m_errs++;
      m_hunting = 1'b1;
    end else begin
      m_buf[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 8) begin
        m_y   = m_buf;
        m_fv  = 1'b1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic step(input bit v, input bit fs, input bit d, input string tag);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    cycle++;
    model_bit(v, fs, d);
    #1;
    chk_all(tag);
  endtask

  task automatic send_frame(input logic [7:0] p, input string tag);
    for (int k = 0; k < 8; k++) step(1'b1, k == 0, p[k], tag);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    cycle += 2;
    m_hunting = 1'b1;
    m_buf = 8'h00; m_cnt = 0; m_y = 8'h00; m_fv = 1'b0; m_se = 1'b0; m_errs = 0;
    #1;
    rst = 1'b0;
    chk_all("reset");
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; cycle = 0;
    do_reset();
    step(1'b0, 1'b0, 1'b0, "idle");
    chk("idle_y", 32'(y), 32'h00);

    send_frame(8'h01, "frame01");
    chk("frame01_y", 32'(y), 32'h01);
    chk("frame01_fv", 32'(frame_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, "frame01_idle");
    chk("frame01_fv_drop", 32'(frame_valid), 32'h0);

    // Back-to-back frames: frame_valid spacing measured in cycles.
    last_fv_cycle = -1;
    foreach (m_buf[i]) ;
    begin
      logic [7:0] pl [3];
      pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
      for (int f = 0; f < 3; f++) begin
        send_frame(pl[f], "b2b");
        chk("b2b_y", 32'(y), 32'(pl[f]));
        if (last_fv_cycle >= 0) chk("b2b_spacing", 32'(cycle - last_fv_cycle), 32'd8);
        last_fv_cycle = cycle;
      end
    end

    // Early sync at slot 4.
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b1, "early_pre");
    step(1'b1, 1'b1, 1'b0, "early_sync");
    chk("early_se", 32'(sync_err), 32'h1);
    chk("early_y_hold", 32'(y), 32'hFF);
    begin
      logic [7:0] rp;
      rp = 8'h6A;
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, rp[k], "early_rest");
      chk("early_new_y", 32'(y), 32'h6A);
      chk("early_new_fv", 32'(frame_valid), 32'h1);
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("early_errcnt", 32'(err_cnt), 32'd1);
`endif

    // Missing sync after a complete frame drops to HUNT.
    send_frame(8'h5A, "pre_miss");
    step(1'b1, 1'b0, 1'b1, "missing_sync");
    chk("miss_se", 32'(sync_err), 32'h1);
    chk("miss_locked", 32'(locked), 32'h0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'($urandom), "hunt_ignore");
    chk("hunt_y_hold", 32'(y), 32'h5A);
    send_frame(8'hC3, "relock");
    chk("relock_y", 32'(y), 32'hC3);

    // Reset mid-frame at slot 5.
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, "pre_rst");
    chk("pre_rst_slot", 32'(slot), 32'd5);
    do_reset();
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_y", 32'(y), 32'h00);
    send_frame(8'h81, "post_rst");
    chk("post_rst_y", 32'(y), 32'h81);

    // Randomized traffic: mostly well-formed frames, gaps and occasional sync corruption.
    begin
      int pos;
      bit v, fs;
      pos = 0;
      for (int i = 0; i < 600; i++) begin
        v = ($urandom_range(3) != 0);
        if (v) begin
          fs = (pos == 0);
          if ($urandom_range(24) == 0) fs = !fs;
          pos = (pos + 1) % 8;
        end else begin
          fs = 1'($urandom);
        end
        step(v, fs, 1'($urandom), "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
